// File: rtl/if_stage_pkg.sv
// Shared pipeline constants and fetch-stage types.
// Holds the fetch vectors and the event encoding used by if_stage.
package if_stage_pkg;

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC   = 32'h8000_0008;
    localparam logic [31:0] NOP       = 32'h0000_0000;

    // Next-state events, listed from lowest to highest priority.
    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_STALL,
        SEL_IRQ,
        SEL_JUMP,
        SEL_EXC,
        SEL_BRANCH
    } pc_sel_e;

    // Bit 31 is the supervisor bit; increment wraps inside bits 30:0 only.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: flush to a bubble, hold, or load a new slot.
// Flush wins over hold, hold wins over load.
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_hold,
    input  logic        i_flush,
    input  logic        i_load,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_next_pc,
    input  logic        i_irq,
    output logic [31:0] o_instr,
    output logic [31:0] o_next_pc,
    output logic        o_valid,
    output logic        o_irq
);

    logic [31:0] r_instr;
    logic [31:0] r_next_pc;
    logic        r_valid;
    logic        r_irq;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr   <= NOP;
            r_next_pc <= 32'h0;
            r_valid   <= 1'b0;
            r_irq     <= 1'b0;
        end else if (i_flush) begin
            r_instr   <= NOP;
            r_next_pc <= 32'h0;
            r_valid   <= 1'b0;
            r_irq     <= 1'b0;
        end else if (!i_hold && i_load) begin
            r_instr   <= i_instr;
            r_next_pc <= i_next_pc;
            r_valid   <= 1'b1;
            r_irq     <= i_irq;
        end
    end

    assign o_instr   = r_instr;
    assign o_next_pc = r_next_pc;
    assign o_valid   = r_valid;
    assign o_irq     = r_irq;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, redirect priority and interrupt entry.
// The ROM is combinational on oPC, so iInstr belongs to the current PC.
module if_stage
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] oPC,
    input  logic [31:0] iInstr,
    input  logic        iStall,
    input  logic        iBranch,
    input  logic [31:0] iBranchTarget,
    input  logic        iJump,
    input  logic [31:0] iJumpTarget,
    input  logic        iIllop,
    input  logic        iIRQ,
    output logic [31:0] oInstr,
    output logic [31:0] oNextPC,
    output logic        oValid,
    output logic        oIRQ
);

    logic [31:0] r_pc;
    logic        r_irq_pending;

    pc_sel_e     w_sel;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    logic        w_pending_next;
    logic        w_flush;
    logic        w_hold;
    logic        w_load;
    logic [31:0] w_load_instr;
    logic [31:0] w_load_npc;
    logic        w_load_irq;

    assign w_pc_plus4 = pc_plus4(r_pc);

    // Interrupts are only taken from user mode; a stall does not block them.
    always_comb begin
        w_sel = SEL_SEQ;
        if (iBranch)
            w_sel = SEL_BRANCH;
        else if (iIllop)
            w_sel = SEL_EXC;
        else if (iJump)
            w_sel = SEL_JUMP;
        else if (r_irq_pending && !r_pc[31])
            w_sel = SEL_IRQ;
        else if (iStall)
            w_sel = SEL_STALL;
    end

    always_comb begin
        w_pc_next      = w_pc_plus4;
        w_pending_next = r_irq_pending | iIRQ;
        w_flush        = 1'b0;
        w_hold         = 1'b0;
        w_load         = 1'b1;
        w_load_instr   = iInstr;
        w_load_npc     = w_pc_plus4;
        w_load_irq     = 1'b0;
        case (w_sel)
            SEL_BRANCH: begin
                w_pc_next = iBranchTarget;
                w_flush   = 1'b1;
            end
            SEL_EXC: begin
                w_pc_next = EXC_VEC;
                w_flush   = 1'b1;
            end
            SEL_JUMP: begin
                w_pc_next = iJumpTarget;
                w_flush   = 1'b1;
            end
            SEL_IRQ: begin
                // Return address is the instruction that was not fetched.
                w_pc_next      = IRQ_VEC;
                w_load_instr   = NOP;
                w_load_npc     = r_pc;
                w_load_irq     = 1'b1;
                w_pending_next = iIRQ;
            end
            SEL_STALL: begin
                w_pc_next = r_pc;
                w_hold    = 1'b1;
                w_load    = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc          <= RESET_VEC;
            r_irq_pending <= 1'b0;
        end else begin
            r_pc          <= w_pc_next;
            r_irq_pending <= w_pending_next;
        end
    end

    if_id_reg u_if_id (
        .clk       (clk),
        .reset     (reset),
        .i_hold    (w_hold),
        .i_flush   (w_flush),
        .i_load    (w_load),
        .i_instr   (w_load_instr),
        .i_next_pc (w_load_npc),
        .i_irq     (w_load_irq),
        .o_instr   (oInstr),
        .o_next_pc (oNextPC),
        .o_valid   (oValid),
        .o_irq     (oIRQ)
    );

    assign oPC = r_pc;

endmodule

// File: tb/tb_if_stage.sv
// Scenario-driven bench for if_stage with a combinational ROM model.
// Each scenario queues the expected fetch/IF-ID state per cycle and pops it after the edge.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic [31:0] oPC;
    logic [31:0] iInstr;
    logic        iStall;
    logic        iBranch;
    logic [31:0] iBranchTarget;
    logic        iJump;
    logic [31:0] iJumpTarget;
    logic        iIllop;
    logic        iIRQ;
    logic [31:0] oInstr;
    logic [31:0] oNextPC;
    logic        oValid;
    logic        oIRQ;

    typedef struct packed {
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic        ill;
        logic        irq;
    } stim_t;

    // {pc, instr, next_pc, valid, irq}
    logic [97:0] exp_q[$];
    int          checks;
    int          errors;

    if_stage dut (
        .clk           (clk),
        .reset         (reset),
        .oPC           (oPC),
        .iInstr        (iInstr),
        .iStall        (iStall),
        .iBranch       (iBranch),
        .iBranchTarget (iBranchTarget),
        .iJump         (iJump),
        .iJumpTarget   (iJumpTarget),
        .iIllop        (iIllop),
        .iIRQ          (iIRQ),
        .oInstr        (oInstr),
        .oNextPC       (oNextPC),
        .oValid        (oValid),
        .oIRQ          (oIRQ)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- ROM model ----------------
    function automatic logic [31:0] rom(input logic [31:0] pc);
        if (pc == 32'h8000_0000)
            return 32'h2008_0001;
        return pc ^ 32'h5A5A_0000;
    endfunction

    always_comb iInstr = rom(oPC);

    // ---------------- helpers ----------------
    function automatic logic [97:0] pk(input logic [31:0] pc, input logic [31:0] instr,
                                       input logic [31:0] npc, input logic v, input logic irq);
        return {pc, instr, npc, v, irq};
    endfunction

    function automatic stim_t mk(input logic stall, input logic br, input logic [31:0] bt,
                                 input logic jmp, input logic [31:0] jt,
                                 input logic ill, input logic irq);
        stim_t s;
        s.stall = stall; s.br = br; s.bt = bt; s.jmp = jmp; s.jt = jt; s.ill = ill; s.irq = irq;
        return s;
    endfunction

    function automatic stim_t s_idle();
        return mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endfunction

    function automatic stim_t s_jump(input logic [31:0] t);
        return mk(1'b0, 1'b0, 32'h0, 1'b1, t, 1'b0, 1'b0);
    endfunction

    // ---------------- driver ----------------
    // Apply one cycle of inputs, clock it, sample 1 time unit after the edge.
    task automatic drive(input stim_t s);
        iStall        = s.stall;
        iBranch       = s.br;
        iBranchTarget = s.bt;
        iJump         = s.jmp;
        iJumpTarget   = s.jt;
        iIllop        = s.ill;
        iIRQ          = s.irq;
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        stim_t       st[$];
        logic [97:0] exp, got;
        reset = 1'b0;
        drive(s_idle());
        @(negedge clk);
        exp_q.push_back(pk(32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b0));
        exp = exp_q.pop_front();
        got = {oPC, oInstr, oNextPC, oValid, oIRQ};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_state: got pc=%h instr=%h npc=%h v=%b irq=%b, expected pc=%h instr=%h npc=%h v=%b irq=%b",
                     got[97:66], got[65:34], got[33:2], got[1], got[0], exp[97:66], exp[65:34], exp[33:2], exp[1], exp[0]);
        end
        reset = 1'b1;
        st.push_back(s_idle()); exp_q.push_back(pk(32'h8000_0004, 32'h2008_0001, 32'h8000_0004, 1'b1, 1'b0));
        st.push_back(s_idle()); exp_q.push_back(pk(32'h8000_0008, rom(32'h8000_0004), 32'h8000_0008, 1'b1, 1'b0));
        foreach (st[k]) begin
            drive(st[k]);
            exp = exp_q.pop_front();
            got = {oPC, oInstr, oNextPC, oValid, oIRQ};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_release[%0d]: got pc=%h instr=%h npc=%h v=%b irq=%b, expected pc=%h instr=%h npc=%h v=%b irq=%b",
                         k, got[97:66], got[65:34], got[33:2], got[1], got[0], exp[97:66], exp[65:34], exp[33:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_stall();
        stim_t       st[$];
        logic [97:0] exp, got;
        st.push_back(s_jump(32'h0040_000C)); exp_q.push_back(pk(32'h0040_000C, 32'h0, 32'h0, 1'b0, 1'b0));
        st.push_back(s_idle());              exp_q.push_back(pk(32'h0040_0010, rom(32'h0040_000C), 32'h0040_0010, 1'b1, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0));
        exp_q.push_back(pk(32'h0040_0010, rom(32'h0040_000C), 32'h0040_0010, 1'b1, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0));
        exp_q.push_back(pk(32'h0040_0010, rom(32'h0040_000C), 32'h0040_0010, 1'b1, 1'b0));
        st.push_back(s_idle());              exp_q.push_back(pk(32'h0040_0014, rom(32'h0040_0010), 32'h0040_0014, 1'b1, 1'b0));
        foreach (st[k]) begin
            drive(st[k]);
            exp = exp_q.pop_front();
            got = {oPC, oInstr, oNextPC, oValid, oIRQ};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL stall[%0d]: got pc=%h instr=%h npc=%h v=%b irq=%b, expected pc=%h instr=%h npc=%h v=%b irq=%b",
                         k, got[97:66], got[65:34], got[33:2], got[1], got[0], exp[97:66], exp[65:34], exp[33:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_branch_over_jump();
        stim_t       st[$];
        logic [97:0] exp, got;
        st.push_back(mk(1'b0, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0200, 1'b0, 1'b0));
        exp_q.push_back(pk(32'h0040_0100, 32'h0, 32'h0, 1'b0, 1'b0));
        st.push_back(s_idle()); exp_q.push_back(pk(32'h0040_0104, rom(32'h0040_0100), 32'h0040_0104, 1'b1, 1'b0));
        foreach (st[k]) begin
            drive(st[k]);
            exp = exp_q.pop_front();
            got = {oPC, oInstr, oNextPC, oValid, oIRQ};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL branch_jump[%0d]: got pc=%h instr=%h npc=%h v=%b irq=%b, expected pc=%h instr=%h npc=%h v=%b irq=%b",
                         k, got[97:66], got[65:34], got[33:2], got[1], got[0], exp[97:66], exp[65:34], exp[33:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_irq_during_stall();
        stim_t       st[$];
        logic [97:0] exp, got;
        st.push_back(s_jump(32'h0040_0020)); exp_q.push_back(pk(32'h0040_0020, 32'h0, 32'h0, 1'b0, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1));
        exp_q.push_back(pk(32'h0040_0020, 32'h0, 32'h0, 1'b0, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0));
        exp_q.push_back(pk(32'h8000_0004, 32'h0, 32'h0040_0020, 1'b1, 1'b1));
        st.push_back(s_idle());              exp_q.push_back(pk(32'h8000_0008, rom(32'h8000_0004), 32'h8000_0008, 1'b1, 1'b0));
        // Pending must have cleared: back in user mode, no second take.
        st.push_back(s_jump(32'h0040_0070)); exp_q.push_back(pk(32'h0040_0070, 32'h0, 32'h0, 1'b0, 1'b0));
        st.push_back(s_idle());              exp_q.push_back(pk(32'h0040_0074, rom(32'h0040_0070), 32'h0040_0074, 1'b1, 1'b0));
        foreach (st[k]) begin
            drive(st[k]);
            exp = exp_q.pop_front();
            got = {oPC, oInstr, oNextPC, oValid, oIRQ};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL irq_stall[%0d]: got pc=%h instr=%h npc=%h v=%b irq=%b, expected pc=%h instr=%h npc=%h v=%b irq=%b",
                         k, got[97:66], got[65:34], got[33:2], got[1], got[0], exp[97:66], exp[65:34], exp[33:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_irq_supervisor();
        stim_t       st[$];
        logic [97:0] exp, got;
        st.push_back(s_jump(32'h8000_0040)); exp_q.push_back(pk(32'h8000_0040, 32'h0, 32'h0, 1'b0, 1'b0));
        st.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1));
        exp_q.push_back(pk(32'h8000_0044, rom(32'h8000_0040), 32'h8000_0044, 1'b1, 1'b0));
        st.push_back(s_idle());              exp_q.push_back(pk(32'h8000_0048, rom(32'h8000_0044), 32'h8000_0048, 1'b1, 1'b0));
        st.push_back(s_jump(32'h0040_0000)); exp_q.push_back(pk(32'h0040_0000, 32'h0, 32'h0, 1'b0, 1'b0));
        st.push_back(s_idle());              exp_q.push_back(pk(32'h8000_0004, 32'h0, 32'h0040_0000, 1'b1, 1'b1));
        st.push_back(s_idle());              exp_q.push_back(pk(32'h8000_0008, rom(32'h8000_0004), 32'h8000_0008, 1'b1, 1'b0));
        foreach (st[k]) begin
            drive(st[k]);
            exp = exp_q.pop_front();
            got = {oPC, oInstr, oNextPC, oValid, oIRQ};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL irq_super[%0d]: got pc=%h instr=%h npc=%h v=%b irq=%b, expected pc=%h instr=%h npc=%h v=%b irq=%b",
                         k, got[97:66], got[65:34], got[33:2], got[1], got[0], exp[97:66], exp[65:34], exp[33:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_irq_retrigger();
        stim_t       st[$];
        logic [97:0] exp, got;
        st.push_back(s_jump(32'h0040_0040)); exp_q.push_back(pk(32'h0040_0040, 32'h0, 32'h0, 1'b0, 1'b0));
        st.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1));
        exp_q.push_back(pk(32'h0040_0044, rom(32'h0040_0040), 32'h0040_0044, 1'b1, 1'b0));
        // Second pulse lands on the take cycle, so pending stays set.
        st.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1));
        exp_q.push_back(pk(32'h8000_0004, 32'h0, 32'h0040_0044, 1'b1, 1'b1));
        st.push_back(s_jump(32'h0040_0050)); exp_q.push_back(pk(32'h0040_0050, 32'h0, 32'h0, 1'b0, 1'b0));
        st.push_back(s_idle());              exp_q.push_back(pk(32'h8000_0004, 32'h0, 32'h0040_0050, 1'b1, 1'b1));
        foreach (st[k]) begin
            drive(st[k]);
            exp = exp_q.pop_front();
            got = {oPC, oInstr, oNextPC, oValid, oIRQ};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL irq_retrig[%0d]: got pc=%h instr=%h npc=%h v=%b irq=%b, expected pc=%h instr=%h npc=%h v=%b irq=%b",
                         k, got[97:66], got[65:34], got[33:2], got[1], got[0], exp[97:66], exp[65:34], exp[33:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_illop_and_wrap();
        stim_t       st[$];
        logic [97:0] exp, got;
        st.push_back(s_jump(32'h0040_0030)); exp_q.push_back(pk(32'h0040_0030, 32'h0, 32'h0, 1'b0, 1'b0));
        st.push_back(s_idle());              exp_q.push_back(pk(32'h0040_0034, rom(32'h0040_0030), 32'h0040_0034, 1'b1, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 32'h0040_0300, 1'b1, 1'b0));
        exp_q.push_back(pk(32'h8000_0008, 32'h0, 32'h0, 1'b0, 1'b0));
        st.push_back(s_jump(32'hFFFF_FFFC)); exp_q.push_back(pk(32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0));
        st.push_back(s_idle());              exp_q.push_back(pk(32'h8000_0000, rom(32'hFFFF_FFFC), 32'h8000_0000, 1'b1, 1'b0));
        foreach (st[k]) begin
            drive(st[k]);
            exp = exp_q.pop_front();
            got = {oPC, oInstr, oNextPC, oValid, oIRQ};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL illop_wrap[%0d]: got pc=%h instr=%h npc=%h v=%b irq=%b, expected pc=%h instr=%h npc=%h v=%b irq=%b",
                         k, got[97:66], got[65:34], got[33:2], got[1], got[0], exp[97:66], exp[65:34], exp[33:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        stim_t       st[$];
        logic [97:0] exp, got;
        st.push_back(s_jump(32'h8000_0010)); exp_q.push_back(pk(32'h8000_0010, 32'h0, 32'h0, 1'b0, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1));
        exp_q.push_back(pk(32'h8000_0010, 32'h0, 32'h0, 1'b0, 1'b0));
        foreach (st[k]) begin
            drive(st[k]);
            exp = exp_q.pop_front();
            got = {oPC, oInstr, oNextPC, oValid, oIRQ};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_mid_pre[%0d]: got pc=%h instr=%h npc=%h v=%b irq=%b, expected pc=%h instr=%h npc=%h v=%b irq=%b",
                         k, got[97:66], got[65:34], got[33:2], got[1], got[0], exp[97:66], exp[65:34], exp[33:2], exp[1], exp[0]);
            end
        end
        // Asynchronous reset between edges while the stall is still applied.
        #2 reset = 1'b0;
        #1;
        exp_q.push_back(pk(32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b0));
        exp = exp_q.pop_front();
        got = {oPC, oInstr, oNextPC, oValid, oIRQ};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_async: got pc=%h instr=%h npc=%h v=%b irq=%b, expected pc=%h instr=%h npc=%h v=%b irq=%b",
                     got[97:66], got[65:34], got[33:2], got[1], got[0], exp[97:66], exp[65:34], exp[33:2], exp[1], exp[0]);
        end
        iStall = 1'b0;
        #2 reset = 1'b1;
        st.delete();
        st.push_back(s_idle());              exp_q.push_back(pk(32'h8000_0004, 32'h2008_0001, 32'h8000_0004, 1'b1, 1'b0));
        st.push_back(s_jump(32'h0040_0060)); exp_q.push_back(pk(32'h0040_0060, 32'h0, 32'h0, 1'b0, 1'b0));
        st.push_back(s_idle());              exp_q.push_back(pk(32'h0040_0064, rom(32'h0040_0060), 32'h0040_0064, 1'b1, 1'b0));
        foreach (st[k]) begin
            drive(st[k]);
            exp = exp_q.pop_front();
            got = {oPC, oInstr, oNextPC, oValid, oIRQ};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_mid_post[%0d]: got pc=%h instr=%h npc=%h v=%b irq=%b, expected pc=%h instr=%h npc=%h v=%b irq=%b",
                         k, got[97:66], got[65:34], got[33:2], got[1], got[0], exp[97:66], exp[65:34], exp[33:2], exp[1], exp[0]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        iStall        = 1'b0;
        iBranch       = 1'b0;
        iBranchTarget = 32'h0;
        iJump         = 1'b0;
        iJumpTarget   = 32'h0;
        iIllop        = 1'b0;
        iIRQ          = 1'b0;

        test_reset();
        test_stall();
        test_branch_over_jump();
        test_irq_during_stall();
        test_irq_supervisor();
        test_irq_retrigger();
        test_illop_and_wrap();
        test_reset_mid_stall();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have port: clk  in  1  rising-edge clock.
REQ-002 The block SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-003 The block SHALL have port: oPC  out  32  fetch address to instruction ROM; the ROM is combinational on this address.
REQ-004 The block SHALL have port: iInstr  in  32  ROM data for oPC, same cycle.
REQ-005 The block SHALL have port: iStall  in  1  load-use hazard from the hazard unit; freezes the PC and the IF/ID register.
REQ-006 The block SHALL have ports: iBranch  in  1  and  iBranchTarget  in  32  taken conditional branch resolved in EX, with its target.
REQ-007 The block SHALL have ports: iJump  in  1  and  iJumpTarget  in  32  J/JAL/JR/JALR resolved in ID, with its target.
REQ-008 The block SHALL have port: iIllop  in  1  illegal opcode detected in ID.
REQ-009 The block SHALL have port: iIRQ  in  1  single-cycle timer interrupt pulse.
REQ-010 The block SHALL have ports: oInstr  out  32  IF/ID instruction; oNextPC  out  32  IF/ID next PC; oValid  out  1  IF/ID slot valid; oIRQ  out  1  IF/ID slot is an interrupt entry.

Function
REQ-011 The block SHALL compute the incremented PC as PC+4 = {PC[31], PC[30:0]+4}, so that bit 31 (the supervisor bit) never changes through incrementing and wraps within bits 30:0.
REQ-012 The block SHALL select exactly one next-state event per cycle, in this priority order: iBranch, then iIllop, then iJump, then the IRQ take, then iStall, then the sequential path.
REQ-013 On iBranch, the PC SHALL load iBranchTarget and the IF/ID register SHALL flush to a bubble (oInstr=0, oNextPC=0, oValid=0, oIRQ=0).
REQ-014 On iIllop with no iBranch, the PC SHALL load 0x80000008 and the IF/ID register SHALL flush to a bubble.
REQ-015 On iJump with no higher-priority event, the PC SHALL load iJumpTarget and the IF/ID register SHALL flush to a bubble.
REQ-016 An internal irq_pending flag SHALL set on iIRQ and SHALL hold until the interrupt is taken.
REQ-017 The interrupt SHALL be taken when irq_pending=1, oPC[31]=0, and iBranch, iIllop and iJump are all 0; iStall SHALL NOT block the take.
REQ-018 On an interrupt take, the PC SHALL load 0x80000004 and the IF/ID register SHALL load oInstr=0, oNextPC=oPC (the return address of the unfetched instruction), oValid=1 and oIRQ=1.
REQ-019 On an interrupt take, irq_pending SHALL clear unless iIRQ is asserted in the same cycle, in which case it SHALL remain set.
REQ-020 While oPC[31]=1 (supervisor mode), irq_pending SHALL remain set and SHALL NOT be taken.
REQ-021 On iStall with no higher-priority event, the PC and the entire IF/ID register SHALL hold their values, and irq_pending SHALL still capture iIRQ.
REQ-022 On the sequential path, the PC SHALL load PC+4 and the IF/ID register SHALL load oInstr=iInstr, oNextPC=PC+4, oValid=1 and oIRQ=0.
REQ-023 Every redirect (branch, exception, jump or IRQ take) SHALL have a latency of one cycle: the target appears on oPC at the next rising edge.
REQ-024 All state changes SHALL occur on the rising edge of clk only, except reset.

Reset
REQ-025 While reset=0, the block SHALL asynchronously force: PC=0x80000000, oInstr=0, oNextPC=0, oValid=0, oIRQ=0 and irq_pending=0.
REQ-026 A reset asserted mid-redirect or mid-stall SHALL discard all pending events, including a pending IRQ.
REQ-027 On the first rising edge after reset deasserts, the block SHALL fetch 0x80000000 normally.

Structure
REQ-028 The values RESET_VEC=0x80000000, IRQ_VEC=0x80000004, EXC_VEC=0x80000008 and NOP=0 SHALL be defined in the shared pipeline package.
REQ-029 The IF/ID register SHALL be implemented as one sub-module, if_id_reg, with hold, flush and load controls.
REQ-030 The PC register, priority selection and irq_pending logic SHALL reside in if_stage.

Verification
REQ-031 The bench SHALL cover reset release with the ROM returning 0x20080001 -> oPC=0x80000000, then 0x80000004; on the second edge oInstr=0x20080001, oNextPC=0x80000004, oValid=1.
REQ-032 The bench SHALL cover iStall=1 for 2 cycles at oPC=0x00400010 -> oPC and all IF/ID outputs unchanged for 2 cycles, then oPC=0x00400014.
REQ-033 The bench SHALL cover iBranch=1 with iBranchTarget=0x00400100 and iJump=1 in the same cycle -> next oPC=0x00400100 and a bubble (oValid=0).
REQ-034 The bench SHALL cover an iIRQ pulse at oPC=0x00400020 during iStall=1 -> next oPC=0x80000004, oIRQ=1, oNextPC=0x00400020, oValid=1.
REQ-035 The bench SHALL cover an iIRQ pulse at oPC=0x80000040 -> no take while oPC[31]=1; after iJump to 0x00400000, the take occurs on the following cycle.
REQ-036 The bench SHALL cover iIllop=1 at oPC=0x00400030 -> next oPC=0x80000008 and a bubble; and, separately, oPC=0xFFFFFFFC on the sequential path -> next oPC=0x80000000 (only bits 30:0 wrap).
